// File: rtl/uart_seq_trig_rx.sv
// ============================================================================
// Module      : uart_seq_trig_rx
// Description : UART receiver for the logic-analyzer trigger path. It
//               receives asynchronous serial frames: one start bit, DATA_W
//               data bits sent LSB first, an optional even-parity bit and
//               one stop bit. Each bit is sampled near its middle. Good
//               frames are checked against a programmable sequence of
//               SEQ_LEN frames. Each bit of the sequence can be marked as
//               don't-care. The module reports framing errors.
// Options     : define UART_TRIG_PARITY_EN to expect one even-parity bit
//               between the data bits and the stop bit.
// Ports       : clk, rst_n      clock, asynchronous active-low reset
//               RX              serial input, idle high
//               baud_cnt        clk cycles per bit (>= 4), change only idle
//               trig_en         arms the sequence matcher
//               match / mask    expected frames / don't-care bits, slice i
//                               = frame i of the sequence
//               rx_data         last good frame (held)
//               rx_rdy          1-cycle pulse per good frame
//               frame_err       1-cycle pulse on bad stop or parity bit
//               UARTtrig        1-cycle pulse when the sequence completes
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_seq_trig_rx #(
    parameter int DATA_W  = 8,
    parameter int SEQ_LEN = 2,
    parameter int BAUD_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      RX,
    input  logic [BAUD_W-1:0]         baud_cnt,
    input  logic                      trig_en,
    input  logic [SEQ_LEN*DATA_W-1:0] match,
    input  logic [SEQ_LEN*DATA_W-1:0] mask,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      rx_rdy,
    output logic                      frame_err,
    output logic                      UARTtrig
);

    localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [BAUD_W-1:0] BAUD_ONE = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SEQ_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [BAUD_W-1:0]    cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_W-1:0]    rx_sr;
    logic [IDX_W-1:0]     seq_idx;
    logic [SEQ_LEN-1:0]   slice_hit;
    logic                 half_tick;
    logic                 bit_tick;
    logic                 hit_cur;
    logic                 stop_ok;
`ifdef UART_TRIG_PARITY_EN
    logic                 par_err;
`endif

    // The start bit is checked half a bit after the falling edge. Every
    // later bit is sampled one full bit period after the previous sample.
    // This keeps the data samples near the middle of each bit.
    assign half_tick = (cnt == (baud_cnt >> 1));
    assign bit_tick  = (cnt == (baud_cnt - BAUD_ONE));

    // Check the shift register against every slice at once. Bits that are
    // set in the mask are forced to 1 on both sides, so they never differ.
    for (genvar i = 0; i < SEQ_LEN; i++) begin : g_slice
        assign slice_hit[i] =
            ((rx_sr | mask[i*DATA_W +: DATA_W]) ==
             (match[i*DATA_W +: DATA_W] | mask[i*DATA_W +: DATA_W]));
    end

    assign hit_cur = slice_hit[seq_idx];

`ifdef UART_TRIG_PARITY_EN
    assign stop_ok = rx_s & ~par_err;
`else
    assign stop_ok = rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            seq_idx   <= '0;
            rx_data   <= '0;
            rx_rdy    <= 1'b0;
            frame_err <= 1'b0;
            UARTtrig  <= 1'b0;
`ifdef UART_TRIG_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            rx_meta   <= RX;
            rx_s      <= rx_meta;
            rx_rdy    <= 1'b0;
            frame_err <= 1'b0;
            UARTtrig  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (half_tick) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= ST_IDLE;   // too short to be a start bit
                        end else begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end else begin
                        cnt <= cnt + BAUD_ONE;
                    end
                end

                ST_DATA: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        rx_sr   <= {rx_s, rx_sr[DATA_W-1:1]};
                        bit_cnt <= bit_cnt + BIT_ONE;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TRIG_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + BAUD_ONE;
                    end
                end

`ifdef UART_TRIG_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        // For even parity, the data bits and the parity bit
                        // together must hold an even number of ones.
                        par_err <= ^{rx_sr, rx_s};
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + BAUD_ONE;
                    end
                end
`endif

                ST_STOP: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (stop_ok) begin
                            rx_data <= rx_sr;
                            rx_rdy  <= 1'b1;
                            if (!trig_en) begin
                                seq_idx <= '0;
                            end else if (hit_cur) begin
                                if (seq_idx == LAST_IDX) begin
                                    UARTtrig <= 1'b1;
                                    seq_idx  <= '0;
                                end else begin
                                    seq_idx <= seq_idx + IDX_ONE;
                                end
                            end else begin
                                // A frame that breaks the sequence can still
                                // be the first frame of a new sequence.
                                seq_idx <= slice_hit[0] ? IDX_ONE : '0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            seq_idx   <= '0;
                        end
                    end else begin
                        cnt <= cnt + BAUD_ONE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase

            // When the matcher is disarmed, the sequence restarts from frame 0.
            if (!trig_en) begin
                seq_idx <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_seq_trig_rx.sv
// ============================================================================
// Module      : tb_uart_seq_trig_rx
// Description : Self-checking bench for uart_seq_trig_rx. It runs directed
//               trigger-sequence scenarios and then random frames. The
//               results are compared with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_seq_trig_rx;

    localparam int DATA_W  = 8;
    localparam int SEQ_LEN = 2;
    localparam int BAUD_W  = 16;
    localparam int BAUD    = 16;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      RX = 1'b1;
    logic [BAUD_W-1:0]         baud_cnt = 16'(BAUD);
    logic                      trig_en = 1'b1;
    logic [SEQ_LEN*DATA_W-1:0] match = 16'hA53C;
    logic [SEQ_LEN*DATA_W-1:0] mask = 16'h0000;
    logic [DATA_W-1:0]         rx_data;
    logic                      rx_rdy;
    logic                      frame_err;
    logic                      UARTtrig;

    uart_seq_trig_rx #(
        .DATA_W  (DATA_W),
        .SEQ_LEN (SEQ_LEN),
        .BAUD_W  (BAUD_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .baud_cnt  (baud_cnt),
        .trig_en   (trig_en),
        .match     (match),
        .mask      (mask),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .frame_err (frame_err),
        .UARTtrig  (UARTtrig)
    );

    always #5 clk = ~clk;

    // Counts of the observed output pulses.
    int n_rdy  = 0;
    int n_err  = 0;
    int n_trig = 0;
    int n_bad  = 0;   // trigger without rx_rdy, or together with frame_err

    always @(negedge clk) begin
        if (rx_rdy)    n_rdy++;
        if (frame_err) n_err++;
        if (UARTtrig) begin
            n_trig++;
            if (!rx_rdy || frame_err) n_bad++;
        end
    end

    // Reference model: how far the received frames have progressed through
    // the expected sequence, plus the expected pulse totals.
    int                m_prog = 0;
    int                e_rdy  = 0;
    int                e_err  = 0;
    int                e_trig = 0;
    logic [DATA_W-1:0] e_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic bit frame_fits(logic [DATA_W-1:0] f, int i);
        logic [DATA_W-1:0] want;
        logic [DATA_W-1:0] dc;
        want = match[i*DATA_W +: DATA_W];
        dc   = mask[i*DATA_W +: DATA_W];
        return ((f ^ want) & ~dc) == '0;
    endfunction

    task automatic model_frame(input logic [DATA_W-1:0] f, input bit good);
        if (!good) begin
            e_err++;
            m_prog = 0;
        end else begin
            e_rdy++;
            e_data = f;
            if (!trig_en) begin
                m_prog = 0;
            end else if (frame_fits(f, m_prog)) begin
                if (m_prog == SEQ_LEN - 1) begin
                    e_trig++;
                    m_prog = 0;
                end else begin
                    m_prog++;
                end
            end else begin
                m_prog = frame_fits(f, 0) ? 1 : 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_rdy"},  32'(n_rdy),   32'(e_rdy));
        check({tag, "_err"},  32'(n_err),   32'(e_err));
        check({tag, "_trig"}, 32'(n_trig),  32'(e_trig));
        check({tag, "_data"}, 32'(rx_data), 32'(e_data));
    endtask

    task automatic bit_time();
        repeat (BAUD) @(negedge clk);
    endtask

    // Sends one frame and leaves two idle bit times after it.
    task automatic send_frame(input logic [DATA_W-1:0] f, input logic stop_v,
                              input logic par_flip);
        @(negedge clk);
        RX = 1'b0;
        bit_time();
        for (int i = 0; i < DATA_W; i++) begin
            RX = f[i];
            bit_time();
        end
`ifdef UART_TRIG_PARITY_EN
        RX = (^f) ^ par_flip;
        bit_time();
`endif
        RX = stop_v;
        bit_time();
        RX = 1'b1;
        bit_time();
        bit_time();
`ifdef UART_TRIG_PARITY_EN
        model_frame(f, stop_v && !par_flip);
`else
        model_frame(f, stop_v == 1'b1);
`endif
    endtask

    task automatic frame_check(input string tag, input logic [DATA_W-1:0] f);
        send_frame(f, 1'b1, 1'b0);
        check_counts(tag);
    endtask

    task automatic set_trig_en(input logic v);
        @(negedge clk);
        trig_en = v;
        if (!v) m_prog = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [DATA_W-1:0] f;
        logic              stop_v;

        // Reset state
        repeat (4) @(negedge clk);
        check("reset_rx_data",   32'(rx_data),   32'h0);
        check("reset_rx_rdy",    32'(rx_rdy),    32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_trig",      32'(UARTtrig),  32'h0);
        rst_n = 1'b1;
        repeat (2 * BAUD) @(negedge clk);

        // Basic two-frame sequence
        frame_check("t1_f0", 8'h3C);
        frame_check("t1_f1", 8'hA5);

        // A repeated first frame restarts the sequence
        frame_check("t2_f0", 8'h3C);
        frame_check("t2_f1", 8'h3C);
        frame_check("t2_f2", 8'hA5);

        // Don't-care bits in the second slice
        mask = 16'h0F00;
        frame_check("t3_f0", 8'h3C);
        frame_check("t3_f1", 8'hA0);
        frame_check("t3_f2", 8'h3C);
        frame_check("t3_f3", 8'hB5);
        mask = 16'h0000;

        // A bad stop bit resets the sequence and leaves rx_data unchanged
        frame_check("t4_pre", 8'h5A);
        send_frame(8'h3C, 1'b0, 1'b0);
        check_counts("t4_bad");
        frame_check("t4_f1", 8'hA5);

        // Short low glitch on an idle line
        @(negedge clk);
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        check_counts("t5_glitch");

        // Matcher disarmed, then disarmed briefly in the middle of a sequence
        set_trig_en(1'b0);
        frame_check("t5_off0", 8'h3C);
        frame_check("t5_off1", 8'hA5);
        set_trig_en(1'b1);
        frame_check("t5_mid0", 8'h3C);
        set_trig_en(1'b0);
        set_trig_en(1'b1);
        frame_check("t5_mid1", 8'hA5);

        // Asynchronous reset in the middle of the data bits
        frame_check("t6_pre", 8'h77);
        @(negedge clk);
        RX = 1'b0;
        bit_time();
        RX = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_rx_data",   32'(rx_data),   32'h0);
        check("t6_rst_rx_rdy",    32'(rx_rdy),    32'h0);
        check("t6_rst_frame_err", 32'(frame_err), 32'h0);
        check("t6_rst_trig",      32'(UARTtrig),  32'h0);
        e_data = '0;
        m_prog = 0;
        RX = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        frame_check("t6_f0", 8'h3C);
        frame_check("t6_f1", 8'hA5);

`ifdef UART_TRIG_PARITY_EN
        // A wrong parity bit on the last frame of the sequence
        frame_check("tp_f0", 8'h3C);
        send_frame(8'hA5, 1'b1, 1'b1);
        check_counts("tp_bad");
`endif

        // Random frames, masks and arming changes
        for (int n = 0; n < 24; n++) begin
            if (n % 6 == 0) begin
                mask = 16'($urandom & $urandom & $urandom);
            end
            if ($urandom_range(0, 5) == 0) begin
                set_trig_en(~trig_en);
            end
            case ($urandom_range(0, 3))
                0:       f = 8'h3C;
                1:       f = 8'hA5;
                2:       f = 8'hA5 ^ (8'($urandom) & mask[15:8]);
                default: f = 8'($urandom_range(0, 255));
            endcase
            stop_v = ($urandom_range(0, 7) != 0);
            send_frame(f, stop_v, 1'b0);
            check_counts("rand");
        end
        set_trig_en(1'b1);

        check("trig_alignment", 32'(n_bad), 32'h0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
